// File: rtl/rvvi_depacketizer.sv
// rvvi_depacketizer -- receive side of the RVVI-over-Ethernet link.
//
// Reassembles one RVVI record per Ethernet frame from a 32-bit word stream.
// Frame layout (little-endian word order): SrcMac[47:0], DstMac[95:48],
// EthType[111:96], rvvi[111+RVVI_W:112], zero pad up to a word boundary.
// Words past the expected frame length (MAC padding/FCS) are drained and
// discarded; frames that end early are dropped and counted.
//
// Optional feature macro: RVVI_DEPKT_FILTER_EN
//   defined   : accept a frame only if DstMac == HostMac and EthType matches.
//   undefined : accept every full-length frame; HostMac/EthType are unused.
//
// Ports:
//   m_axi_aclk, m_axi_aresetn   clock, asynchronous active-low reset
//   RvviAxiRdata/Rstrb/Rlast/Rvalid, RvviAxiRready   word stream in (Rstrb ignored)
//   HostMac, EthType            expected destination MAC / EtherType
//   rvvi, RxSrcMac, RvviValid, RvviReady   record out (valid/ready)
//   FrameCount, DropCount       accepted records / dropped frames, wrapping

package rvvi_depkt_pkg;
    typedef struct packed {
        int unsigned XLEN;
    } cvw_t;
endpackage

module rvvi_depacketizer
    import rvvi_depkt_pkg::*;
#(
    parameter cvw_t P        = '{XLEN: 32'd64},
    parameter int   MAX_CSRS = 5,
    localparam int  RVVI_W   = 72 + 5 * int'(P.XLEN) + MAX_CSRS * (int'(P.XLEN) + 16)
) (
    input  logic              m_axi_aclk,
    input  logic              m_axi_aresetn,
    input  logic [31:0]       RvviAxiRdata,
    input  logic [3:0]        RvviAxiRstrb,
    input  logic              RvviAxiRlast,
    input  logic              RvviAxiRvalid,
    output logic              RvviAxiRready,
    input  logic [47:0]       HostMac,
    input  logic [15:0]       EthType,
    output logic [RVVI_W-1:0] rvvi,
    output logic [47:0]       RxSrcMac,
    output logic              RvviValid,
    input  logic              RvviReady,
    output logic [31:0]       FrameCount,
    output logic [31:0]       DropCount
);

    localparam int NEAR_BITS  = 112 + RVVI_W;
    // A frame already on a word boundary still carries one full pad word.
    localparam int TOTAL_BITS = NEAR_BITS + (32 - NEAR_BITS % 32);
    localparam int NUM_WORDS  = TOTAL_BITS / 32;
    localparam logic [9:0] LAST_IDX = 10'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        ST_RST,
        ST_RECV,
        ST_DRAIN,
        ST_CHECK,
        ST_HOLD
    } state_e;

    state_e                state_q,       state_d;
    logic [9:0]            word_idx_q,    word_idx_d;
    logic [TOTAL_BITS-1:0] frame_q,       frame_d;
    logic [RVVI_W-1:0]     rvvi_q,        rvvi_d;
    logic [47:0]           src_mac_q,     src_mac_d;
    logic [31:0]           frame_count_q, frame_count_d;
    logic [31:0]           drop_count_q,  drop_count_d;

    logic beat;
    logic accept;

    // Ready comes from registered state only, never from Rvalid.
    assign RvviAxiRready = (state_q == ST_RECV) || (state_q == ST_DRAIN);
    assign RvviValid     = (state_q == ST_HOLD);
    assign beat          = RvviAxiRvalid && RvviAxiRready;

`ifdef RVVI_DEPKT_FILTER_EN
    assign accept = (frame_q[95:48] == HostMac) && (frame_q[111:96] == EthType);
`else
    assign accept = 1'b1;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_d       = state_q;
        word_idx_d    = word_idx_q;
        frame_d       = frame_q;
        rvvi_d        = rvvi_q;
        src_mac_d     = src_mac_q;
        frame_count_d = frame_count_q;
        drop_count_d  = drop_count_q;

        case (state_q)
            ST_RST: begin
                state_d    = ST_RECV;
                word_idx_d = '0;
            end
            ST_RECV: begin
                if (beat) begin
                    frame_d[{word_idx_q, 5'd0} +: 32] = RvviAxiRdata;
                    if (RvviAxiRlast) begin
                        if (word_idx_q == LAST_IDX) begin
                            state_d = ST_CHECK;
                        end else begin
                            // Short frame: count it and restart on the next word.
                            drop_count_d = drop_count_q + 32'd1;
                            word_idx_d   = '0;
                        end
                    end else if (word_idx_q == LAST_IDX) begin
                        state_d = ST_DRAIN;
                    end else begin
                        word_idx_d = word_idx_q + 10'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (beat && RvviAxiRlast) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (accept) begin
                    rvvi_d    = frame_q[111+RVVI_W:112];
                    src_mac_d = frame_q[47:0];
                    state_d   = ST_HOLD;
                end else begin
                    drop_count_d = drop_count_q + 32'd1;
                    word_idx_d   = '0;
                    state_d      = ST_RECV;
                end
            end
            ST_HOLD: begin
                if (RvviReady) begin
                    frame_count_d = frame_count_q + 32'd1;
                    word_idx_d    = '0;
                    state_d       = ST_RECV;
                end
            end
            default: begin
                state_d = ST_RST;
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q       <= ST_RST;
            word_idx_q    <= '0;
            // NOTE: the wide frame register is reset too, so a partial frame never survives a reset.
            frame_q       <= '0;
            rvvi_q        <= '0;
            src_mac_q     <= '0;
            frame_count_q <= '0;
            drop_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            word_idx_q    <= word_idx_d;
            frame_q       <= frame_d;
            rvvi_q        <= rvvi_d;
            src_mac_q     <= src_mac_d;
            frame_count_q <= frame_count_d;
            drop_count_q  <= drop_count_d;
        end
    end

    assign rvvi       = rvvi_q;
    assign RxSrcMac   = src_mac_q;
    assign FrameCount = frame_count_q;
    assign DropCount  = drop_count_q;

    // Strobes, pad bits and (without the filter) the match inputs are unused.
    logic unused_bits;
    assign unused_bits = ^{RvviAxiRstrb, HostMac, EthType, frame_q[TOTAL_BITS-1:112+RVVI_W]};

endmodule
